// File: rtl/cla_nibble_seq_if.sv
// rtl/cla_nibble_seq_if.sv - operand/result handshake bundle for cla_nibble_seq
interface cla_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         V;
    logic         busy;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, V, busy
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, V, busy
    );
endinterface

// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - wide adder built by sequencing one 4-bit carry-lookahead slice
module cla_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_nibble_seq_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   s_reg;
    logic           carry_reg;
    logic [IW-1:0]  idx;
    logic           cout_reg;
    logic           v_reg;

    logic           accept;
    logic           last;
    logic [IW+1:0]  bit_pos;

    // cla slice signals: operands, generate/propagate, carries C[0..4], sum
    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     nib_g;
    logic [3:0]     nib_p;
    logic [4:0]     nib_c;
    logic [3:0]     nib_s;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign last    = (idx == LAST_IDX);
    assign bit_pos = {idx, 2'b00};
    assign nib_a   = a_reg[bit_pos +: 4];
    assign nib_b   = b_reg[bit_pos +: 4];

    // 4-bit carry-lookahead slice: every carry is a flat sum of products of g/p and carry_reg
    always_comb begin
        nib_g    = nib_a & nib_b;
        nib_p    = nib_a ^ nib_b;
        nib_c[0] = carry_reg;
        nib_c[1] = nib_g[0]
                 | (nib_p[0] & carry_reg);
        nib_c[2] = nib_g[1]
                 | (nib_p[1] & nib_g[0])
                 | (nib_p[1] & nib_p[0] & carry_reg);
        nib_c[3] = nib_g[2]
                 | (nib_p[2] & nib_g[1])
                 | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & carry_reg);
        nib_c[4] = nib_g[3]
                 | (nib_p[3] & nib_g[2])
                 | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_reg);
        nib_s    = nib_p ^ nib_c[3:0];
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept -> NIBBLES RUN cycles -> hold in DONE until the consumer takes it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-nibble sum/carry update, and final Cout/V latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout_reg  <= 1'b0;
            v_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= bus.A;
                        b_reg     <= bus.B;
                        carry_reg <= bus.Cin;
                        idx       <= '0;
                        s_reg     <= '0;
                    end
                end
                RUN: begin
                    s_reg[bit_pos +: 4] <= nib_s;
                    carry_reg           <= nib_c[4];
                    if (last) begin
                        idx      <= '0;
                        cout_reg <= nib_c[4];
                        v_reg    <= nib_c[3] ^ nib_c[4];
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The partially assembled sum is hidden while RUN is still filling it in
    assign bus.S         = (state == RUN) ? '0 : s_reg;
    assign bus.Cout      = cout_reg;
    assign bus.V         = v_reg;
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
endmodule
